// File: rtl/trng_sampler_pkg.sv
// rtl/trng_sampler_pkg.sv - shared TRNG constants and FSM state encoding
// Holds the sampler FSM states and the default word width, sample divider
// and repetition-count cutoff used by trng_sampler.
package trng_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2,
        ERR     = 2'd3
    } trng_state_e;

    localparam int TRNG_WIDTH      = 32;
    localparam int TRNG_DIV        = 8;
    localparam int TRNG_RCT_CUTOFF = 32;

endpackage

// File: rtl/trng_sampler_vn_corrector.sv
// rtl/trng_sampler_vn_corrector.sv - von Neumann debiaser over non-overlapping sample pairs
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   i_sample_strobe    a new raw sample is present on i_raw_bit
//   i_raw_bit          raw sample value
//   i_clear            drop any stored half pair (priority over the strobe)
//   o_out_valid        a debiased bit is emitted this cycle
//   o_out_bit          the emitted bit (first bit of a 10 or 01 pair)
module vn_corrector (
    input  logic clk,
    input  logic rst,
    input  logic i_sample_strobe,
    input  logic i_raw_bit,
    input  logic i_clear,
    output logic o_out_valid,
    output logic o_out_bit
);

    logic r_have_first;
    logic r_first;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_have_first <= 1'b0;
            r_first      <= 1'b0;
        end else if (i_sample_strobe) begin
            // Alternate between capturing the first bit and closing the pair.
            r_have_first <= ~r_have_first;
            if (!r_have_first) begin
                r_first <= i_raw_bit;
            end
        end
    end

    // The output is combinational on the second sample so the packer sees the
    // bit in the same cycle the pair completes: 01 -> 0, 10 -> 1.
    assign o_out_valid = i_sample_strobe && !i_clear && r_have_first && (r_first != i_raw_bit);
    assign o_out_bit   = r_first;

endmodule

// File: rtl/trng_sampler.sv
// rtl/trng_sampler.sv - ring-oscillator TRNG sampler with debiasing and repetition-count health test
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   en         enable bit collection
//   ro[3:0]    ring-oscillator outputs, asynchronous to clk
//   data_out   collected random word (zero while in ERR)
//   valid      data_out holds an untransferred word
//   ready      consumer accepts the word
//   error      sticky repetition-count health failure
module trng_sampler
    import trng_sampler_pkg::*;
#(
    parameter int WIDTH      = TRNG_WIDTH,
    parameter int DIV        = TRNG_DIV,
    parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       ro,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             error
);

    localparam int DIV_W = $clog2(DIV);
    localparam int BIT_W = $clog2(WIDTH);
    localparam int RCT_W = $clog2(RCT_CUTOFF + 1);

    trng_state_e        r_state;
    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bitcnt;
    logic [WIDTH-1:0]   r_word;
    logic [RCT_W-1:0]   r_rct;
    logic               r_prev;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_error;

    logic               w_raw;
    logic               w_collect;
    logic               w_strobe;
    logic [RCT_W-1:0]   w_rct_next;
    logic               w_trip;
    logic               w_vn_valid;
    logic               w_vn_bit;
    logic [WIDTH-1:0]   w_word_next;
    logic               w_last_bit;

    assign w_raw     = ^r_sync2;
    // Sampling only happens while collecting with en still high; dropping en
    // discards the current sample slot together with the partial word.
    assign w_collect = (r_state == COLLECT) && en;
    assign w_strobe  = w_collect && (r_div == DIV_W'(DIV - 1));

    // Saturating so the count can never wrap back below the cutoff.
    always_comb begin
        w_rct_next = RCT_W'(1);
        if (w_raw == r_prev) begin
            w_rct_next = (r_rct >= RCT_W'(RCT_CUTOFF)) ? r_rct : r_rct + RCT_W'(1);
        end
    end

    assign w_trip      = w_strobe && (w_rct_next >= RCT_W'(RCT_CUTOFF));
    assign w_word_next = {r_word[WIDTH-2:0], w_vn_bit};
    assign w_last_bit  = w_vn_valid && (r_bitcnt == BIT_W'(WIDTH - 1));

    vn_corrector u_vn (
        .clk             (clk),
        .rst             (rst),
        .i_sample_strobe (w_strobe),
        .i_raw_bit       (w_raw),
        .i_clear         (!w_collect),
        .o_out_valid     (w_vn_valid),
        .o_out_bit       (w_vn_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_word   <= '0;
            r_rct    <= '0;
            r_prev   <= 1'b0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_sync1 <= ro;
            r_sync2 <= r_sync1;

            if (w_strobe) begin
                r_rct  <= w_rct_next;
                r_prev <= w_raw;
            end

            if (w_trip) begin
                // Strobes only exist in COLLECT, but the trip is written to win
                // from any state; a handshake in the same cycle has already
                // transferred the word, so valid simply drops.
                r_state <= ERR;
                r_error <= 1'b1;
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_div    <= '0;
                        r_bitcnt <= '0;
                        r_word   <= '0;
                        if (en) begin
                            r_state <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (!en) begin
                            r_state  <= IDLE;
                            r_div    <= '0;
                            r_bitcnt <= '0;
                            r_word   <= '0;
                        end else begin
                            r_div <= (r_div == DIV_W'(DIV - 1)) ? '0 : r_div + DIV_W'(1);
                            if (w_last_bit) begin
                                r_data   <= w_word_next;
                                r_valid  <= 1'b1;
                                r_state  <= FULL;
                                r_div    <= '0;
                                r_bitcnt <= '0;
                                r_word   <= '0;
                            end else if (w_vn_valid) begin
                                r_word   <= w_word_next;
                                r_bitcnt <= r_bitcnt + BIT_W'(1);
                            end
                        end
                    end
                    FULL: begin
                        // Divider frozen; en only decides where to go after the transfer.
                        if (r_valid && ready) begin
                            r_valid <= 1'b0;
                            r_div   <= '0;
                            r_state <= en ? COLLECT : IDLE;
                        end
                    end
                    ERR: begin
                        r_valid <= 1'b0;
                        r_data  <= '0;
                        r_error <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out = r_data;
    assign valid    = r_valid;
    assign error    = r_error;

endmodule

// File: tb/tb_trng_sampler.sv
// tb/tb_trng_sampler.sv - scoreboard testbench for trng_sampler
module tb_trng_sampler;

    localparam int WIDTH = 32;
    localparam int DIV   = 8;
    localparam int RCT   = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [3:0]       ro = 4'b0000;
    logic             ready = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             error;

    int               n_tests = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] sb_q[$];
    bit               rand_ready = 1'b0;
    bit               last_raw = 1'b0;
    int               run_len = 0;

    trng_sampler #(.WIDTH(WIDTH), .DIV(DIV), .RCT_CUTOFF(RCT)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ro       (ro),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word is compared against the oldest expected word.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_word", data_out, 32'hDEAD_BEEF);
            end else begin
                check("word", data_out, sb_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) ready = ($urandom_range(0, 1) == 1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] ro_for(input bit b);
        logic [3:0] r;
        r = 4'($urandom_range(0, 15));
        if ((^r) != b) r[0] = ~r[0];
        return r;
    endfunction

    // pat 0: random (long runs broken up), 1: 0,1,..  2: 1,0,..  3: 1,0,0,1,..
    function automatic bit next_bit(input int pat, input int n);
        bit b;
        case (pat)
            1: b = (n % 2) == 1;
            2: b = (n % 2) == 0;
            3: b = ((n % 4) == 0) || ((n % 4) == 3);
            default: begin
                b = ($urandom_range(0, 1) == 1);
                if (run_len >= 20 && b == last_raw) b = !b;
            end
        endcase
        return b;
    endfunction

    // Starts collection from IDLE and feeds one raw bit per sample slot. The
    // reference model pairs the raw bits, keeps the differing-pair first bits
    // and pushes the word once WIDTH of them exist.
    task automatic session(input int pat, input int max_samples, input bit keep_en);
        int               n_emit = 0;
        logic [WIDTH-1:0] word = '0;
        bit               have = 1'b0;
        bit               first = 1'b0;
        bit               b;
        @(posedge clk);
        #1 en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < max_samples && n_emit < WIDTH; n++) begin
            b = next_bit(pat, n);
            ro = ro_for(b);
            run_len = (b == last_raw) ? run_len + 1 : 1;
            last_raw = b;
            if (!have) begin
                have = 1'b1;
                first = b;
            end else begin
                have = 1'b0;
                if (first != b) begin
                    word = {word[WIDTH-2:0], first};
                    n_emit++;
                    if (n_emit == WIDTH) sb_q.push_back(word);
                end
            end
            repeat (DIV) @(posedge clk);
            #1;
        end
        if (!keep_en) en = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        last_raw = 1'b0;
        run_len = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", valid, 0);
        check("rst_error", error, 0);
        check("rst_data", data_out, 0);

        rand_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            session(0, 2000, 1'b0);
            drain();
        end
        rand_ready = 1'b0;
        ready = 1'b1;

        for (int p = 1; p <= 3; p++) begin
            session(p, 1000, 1'b0);
            drain();
        end
        check("no_error_after_data", error, 0);

        // Partial word of zeros plus a half pair, then re-enable with 1,0 stimulus.
        session(1, 21, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("en_drop_valid", valid, 0);
        session(2, 1000, 1'b0);
        drain();

        // Word held while the consumer stalls and ro keeps moving.
        @(posedge clk);
        #1 ready = 1'b0;
        session(2, 1000, 1'b1);
        for (int i = 0; i < 100; i++) begin
            ro = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            check("hold_valid", valid, 1);
            check("hold_data", data_out, 32'hFFFF_FFFF);
        end
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        en = 1'b0;
        check("pulse_valid_drop", valid, 0);
        repeat (2) @(posedge clk);
        #1 check("pulse_drained", sb_q.size(), 0);

        // Reset while a word is pending.
        session(2, 1000, 1'b0);
        check("full_valid", valid, 1);
        do_reset();
        check("rst_full_valid", valid, 0);
        check("rst_full_error", error, 0);
        check("rst_full_data", data_out, 0);
        ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            ro = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        check("idle_no_valid", valid, 0);

        // Constant raw zero: error one cycle after the RCT-th sample.
        ro = 4'b0000;
        @(posedge clk);
        #1 en = 1'b1;
        repeat (RCT * DIV) @(posedge clk);
        #1;
        check("rct_pre", error, 0);
        check("rct_pre_valid", valid, 0);
        @(posedge clk);
        #1;
        check("rct_trip", error, 1);
        check("rct_trip_valid", valid, 0);
        en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ro = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
        end
        en = 1'b0;
        check("err_sticky", error, 1);
        check("err_valid", valid, 0);
        check("err_data", data_out, 0);

        do_reset();
        check("rst_err_error", error, 0);
        check("rst_err_valid", valid, 0);
        check("rst_err_data", data_out, 0);
        repeat (20) @(posedge clk);
        #1 check("post_err_idle", valid, 0);
        session(3, 1000, 1'b0);
        drain();
        check("final_error", error, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trng_sampler.md
TRNG_SAMPLER -- requirements
Module: trng_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning output word width in bits.
REQ-002 SHALL have parameter DIV, default 8, meaning clk cycles per raw sample (DIV >= 2).
REQ-003 SHALL have parameter RCT_CUTOFF, default 32, meaning identical consecutive raw samples that trip the health error.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  enable bit collection.
REQ-007 SHALL have port ro  input  4  ring-oscillator pair outputs, asynchronous to clk.
REQ-008 SHALL have port data_out  output  WIDTH  collected random word.
REQ-009 SHALL have port valid  output  1  data_out holds an untransferred word.
REQ-010 SHALL have port ready  input  1  consumer accepts the word.
REQ-011 SHALL have port error  output  1  sticky repetition-count health failure.

Function
REQ-012 SHALL pass each ro bit through a 2-FF synchronizer; the raw bit is s[0]^s[1]^s[2]^s[3].
REQ-013 SHALL run a divider counter 0..DIV-1 while collecting; the sample strobe fires when the counter equals DIV-1, then the counter wraps to 0.
REQ-014 SHALL apply a von Neumann corrector on consecutive strobed raw bits taken as pairs (first, second): 01 -> emit 0; 10 -> emit 1; 00 and 11 -> emit nothing; pairs do not overlap.
REQ-015 SHALL shift each emitted bit into the word LSB side (word <= {word[WIDTH-2:0], bit}) and increment a bit counter.
REQ-016 SHALL use the FSM states IDLE, COLLECT, FULL and ERR.
REQ-017 IDLE -> COLLECT when en=1; divider, pair state, bit counter and word are cleared on entry.
REQ-018 COLLECT: on the WIDTH-th emitted bit, data_out SHALL load the completed word and valid SHALL rise the next cycle; the FSM then enters FULL.
REQ-019 FULL: valid and data_out SHALL stay stable, the divider SHALL stop and ro SHALL be ignored until valid&&ready.
REQ-020 On valid&&ready, valid SHALL drop the next cycle and the FSM SHALL go to COLLECT if en=1, else IDLE.
REQ-021 en=0 in COLLECT SHALL go to IDLE the next cycle and discard the partial word and any half pair.
REQ-022 en=0 in FULL SHALL NOT drop valid; the pending word is still delivered.
REQ-023 SHALL run a repetition counter on strobed raw bits: it resets to 1 when a sample differs from the previous sample and increments when equal.
REQ-024 When the repetition counter reaches RCT_CUTOFF, error SHALL rise the next cycle and the FSM SHALL enter ERR from any state.
REQ-025 In ERR, valid SHALL be 0, data_out SHALL be 0 and no sampling SHALL occur; only rst exits ERR.
REQ-026 A health trip and a handshake in the same cycle SHALL complete the transfer, then enter ERR.
REQ-027 SHALL size counters to $clog2 of their range; the bit counter SHALL never wrap past WIDTH.

Reset
REQ-028 rst SHALL take priority over all inputs and, on the next cycle, set data_out=0, valid=0 and error=0, state IDLE, all counters and synchronizers to 0, and the repetition counter to 0, so the first sample counts as 1.
REQ-029 rst asserted mid-FULL SHALL discard the pending word without any handshake.

Structure
REQ-030 The shared TRNG package SHALL hold the FSM state encoding and the default WIDTH, DIV and RCT_CUTOFF constants.
REQ-031 The von Neumann corrector SHALL be a sub-module vn_corrector (inputs: sample strobe, raw bit, clear; outputs: out_valid, out_bit).
REQ-032 The synchronizer, divider, RCT, packing and FSM SHALL stay in trng_sampler.

Verification
REQ-033 Scenario: ro held at 4'b0000, en=1 -> error rises 1 cycle after the 32nd strobe; valid never rises.
REQ-034 Scenario: raw bit alternating 0,1 per strobe -> data_out=32'h00000000 with valid after 64 strobes; error stays 0.
REQ-035 Scenario: raw bit alternating 1,0 per strobe -> data_out=32'hFFFFFFFF; raw pattern 1,0,0,1 repeated -> data_out=32'hAAAAAAAA.
REQ-036 Scenario: word complete with ready=0 for 100 cycles while ro toggles -> valid=1 and data_out unchanged throughout; ready pulse of 1 cycle -> valid=0 the next cycle.
REQ-037 Scenario: en dropped after 10 bits collected, then re-raised -> the next word contains only post-re-enable bits (alternating 1,0 stimulus gives 32'hFFFFFFFF, no stale zeros).
REQ-038 Scenario: rst pulsed while in FULL or ERR -> next cycle valid=0, error=0, data_out=0, and collection restarts only after en=1.
